// File: rtl/board_ctl_pkg.sv
// Shared types and defaults for the board reset/run-status controller.
// Contents: FSM state encoding (state_e), STATE_W, default parameter values.
package board_ctl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_PERIPH = 3'd1,
        ST_RUN    = 3'd2,
        ST_PASS   = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_STAGE_GAP      = 8;
    localparam int DEF_SUCCESS_STABLE = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;
    localparam int DEF_CNT_W          = 32;

endpackage

// File: rtl/rst_sync_n.sv
// Async-assert / sync-deassert reset synchronizer.
// Ports:
//   clock      - destination clock
//   reset      - raw active-low reset (asynchronous)
//   rst_sync_n - active-low reset, deasserts SYNC_STAGES-1 edges after the
//                first edge that sees reset high
module rst_sync_n #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/board_reset_sequencer.sv
// Board reset sequencer: synchronizes the pin reset, releases periph_rst_n then
// core_rst_n in stages, then watches a debounced io_success and reports
// done/pass/fail plus the number of cycles spent running.
// Optional build macro BRS_WATCHDOG_EN: enables the RUN timeout into FAIL.
// Ports:
//   clock, reset (async active-low), sw_reset_req (sync restart pulse)
//   io_success   - asynchronous completion flag from the board
//   periph_rst_n, core_rst_n - staged active-low resets to the board
//   state, done, pass, fail, cycle_count - registered run status
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_RESET  | both board resets held; hold_cnt runs after sync reset
// ST_PERIPH | peripherals released; gap_cnt runs before core release
// ST_RUN    | cores running; cycle_count and success debounce active
// ST_PASS   | io_success qualified; terminal until sw_reset_req
// ST_FAIL   | watchdog expired; terminal until sw_reset_req
module board_reset_sequencer
    import board_ctl_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP      = DEF_STAGE_GAP,
    parameter int SUCCESS_STABLE = DEF_SUCCESS_STABLE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sw_reset_req,
    input  logic               io_success,
    output logic               periph_rst_n,
    output logic               core_rst_n,
    output logic [STATE_W-1:0] state,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int STB_W  = $clog2(SUCCESS_STABLE + 1);

`ifdef BRS_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic rst_sync;

    rst_sync_n #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clock     (clock),
        .reset     (reset),
        .rst_sync_n(rst_sync)
    );

    logic [1:0]       succ_sync_q;
    state_e           state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic periph_q, periph_d, core_q, core_d;
    logic done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic success_qual, wd_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            succ_sync_q <= '0;
        end else begin
            succ_sync_q <= {succ_sync_q[0], io_success};
        end
    end

    // Qualification fires on the edge where stable_cnt would reach the
    // threshold, so PASS and the final count land on the same edge.
    assign success_qual = (state_q == ST_RUN) && succ_sync_q[1] &&
                          (stable_q >= STB_W'(SUCCESS_STABLE - 1));
    // WD_EN folds this to 0 when the watchdog is not built.
    assign wd_hit = WD_EN && (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        stable_d = '0;
        cycle_d  = cycle_q;

        if (sw_reset_req) begin
            state_d = ST_RESET;
            hold_d  = '0;
            gap_d   = '0;
            cycle_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rst_sync) begin
                        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                            state_d = ST_PERIPH;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                ST_PERIPH: begin
                    if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
                        state_d = ST_RUN;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cycle_q != '1) begin
                        cycle_d = cycle_q + CNT_W'(1);
                    end
                    if (succ_sync_q[1] && (stable_q != STB_W'(SUCCESS_STABLE))) begin
                        stable_d = stable_q + STB_W'(1);
                    end else if (succ_sync_q[1]) begin
                        stable_d = stable_q;
                    end
                    if (success_qual) begin
                        state_d = ST_PASS;
                    end else if (wd_hit) begin
                        state_d = ST_FAIL;
                    end
                end
                ST_PASS, ST_FAIL: begin
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end

        periph_d = (state_d != ST_RESET);
        core_d   = (state_d == ST_RUN) || (state_d == ST_PASS) || (state_d == ST_FAIL);
        done_d   = (state_d == ST_PASS) || (state_d == ST_FAIL);
        pass_d   = (state_d == ST_PASS);
        fail_d   = (state_d == ST_FAIL);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RESET;
            hold_q   <= '0;
            gap_q    <= '0;
            stable_q <= '0;
            cycle_q  <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
            stable_q <= stable_d;
            cycle_q  <= cycle_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign periph_rst_n = periph_q;
    assign core_rst_n   = core_q;
    assign state        = state_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_board_reset_sequencer.sv
// Directed bench for board_reset_sequencer (default parameters, TIMEOUT_CYCLES=100).
// Build with BRS_WATCHDOG_EN defined to exercise the timeout into FAIL.
module tb_board_reset_sequencer;
    import board_ctl_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sw_reset_req = 1'b0;
    logic        io_success = 1'b0;
    logic        periph_rst_n, core_rst_n, done, pass, fail;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    board_reset_sequencer #(
        .SYNC_STAGES   (2),
        .HOLD_CYCLES   (16),
        .STAGE_GAP     (8),
        .SUCCESS_STABLE(4),
        .TIMEOUT_CYCLES(100),
        .CNT_W         (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sw_reset_req(sw_reset_req),
        .io_success  (io_success),
        .periph_rst_n(periph_rst_n),
        .core_rst_n  (core_rst_n),
        .state       (state),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .cycle_count (cycle_count)
    );

    // Advance n active edges; inputs and checks happen 2 time units after an edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks state and every status/reset output implied by that state.
    task automatic check_st(input string tag, input state_e st);
        check({tag, ".state"},  32'(state), 32'(st));
        check({tag, ".periph"}, 32'(periph_rst_n), 32'(st != ST_RESET));
        check({tag, ".core"},   32'(core_rst_n), 32'(st == ST_RUN || st == ST_PASS || st == ST_FAIL));
        check({tag, ".done"},   32'(done), 32'(st == ST_PASS || st == ST_FAIL));
        check({tag, ".pass"},   32'(pass), 32'(st == ST_PASS));
        check({tag, ".fail"},   32'(fail), 32'(st == ST_FAIL));
    endtask

    // Steps edges k0..kp+8; periph releases at edge kp, core at kp+8.
    task automatic release_seq(input string tag, input int k0, input int kp);
        state_e exp;
        for (int k = k0; k <= kp + 8; k++) begin
            step(1);
            exp = (k >= kp + 8) ? ST_RUN : (k >= kp) ? ST_PERIPH : ST_RESET;
            check_st($sformatf("%s.E%0d", tag, k), exp);
        end
    endtask

    initial begin
        // Pin reset held low.
        step(3);
        check_st("rst_low", ST_RESET);
        check("rst_low.cnt", cycle_count, 32'd0);

        // Release between edges: next edge is E0; periph at E17, core at E25.
        reset = 1'b1;
        release_seq("pin_rel", 0, 17);
        check("pin_rel.cnt", cycle_count, 32'd0);

        // io_success continuously high from sampling edge S=E26 -> PASS at S+5.
        io_success = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check_st($sformatf("pass1.k%0d", k), (k == 6) ? ST_PASS : ST_RUN);
            check($sformatf("pass1.cnt%0d", k), cycle_count, 32'(k));
        end
        io_success = 1'b0;
        step(5);
        check_st("pass1.hold", ST_PASS);
        check("pass1.frozen", cycle_count, 32'd6);

        // sw_reset_req in PASS: immediate RESET, then release at +16 / +24.
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        check_st("swr.P", ST_RESET);
        check("swr.cnt", cycle_count, 32'd0);
        release_seq("swr_rel", 1, 16);

        // Glitch: 3 high, 1 low, then high; PASS only after second burst qualifies.
        for (int k = 1; k <= 10; k++) begin
            io_success = (k != 4);
            step(1);
            check_st($sformatf("glitch.k%0d", k), (k == 10) ? ST_PASS : ST_RUN);
        end
        check("glitch.cnt", cycle_count, 32'd10);
        io_success = 1'b0;

        // Async reset in the middle of PERIPH.
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        step(18);
        check_st("async.pre", ST_PERIPH);
        #1;
        reset = 1'b0;
        #1;
        check_st("async.now", ST_RESET);
        check("async.cnt", cycle_count, 32'd0);
        step(2);
        reset = 1'b1;
        release_seq("async_rel", 0, 17);

        // io_success held low for 100+ RUN edges.
        step(99);
        check_st("wd.e99", ST_RUN);
        check("wd.cnt99", cycle_count, 32'd99);
        step(1);
`ifdef BRS_WATCHDOG_EN
        check_st("wd.e100", ST_FAIL);
        check("wd.cnt100", cycle_count, 32'd100);
        step(5);
        check_st("wd.after", ST_FAIL);
        check("wd.frozen", cycle_count, 32'd100);
`else
        check_st("wd.e100", ST_RUN);
        check("wd.cnt100", cycle_count, 32'd100);
        step(5);
        check_st("wd.after", ST_RUN);
        check("wd.cnt105", cycle_count, 32'd105);
`endif

        // Success qualifying on the same edge as the timeout: PASS wins.
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        step(24);
        check_st("race.run", ST_RUN);
        step(94);
        check("race.cnt94", cycle_count, 32'd94);
        io_success = 1'b1;
        step(5);
        check_st("race.e99", ST_RUN);
        check("race.cnt99", cycle_count, 32'd99);
        step(1);
        check_st("race.e100", ST_PASS);
        check("race.cnt100", cycle_count, 32'd100);
        io_success = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
